// File: rtl/panel_input_ctrl.sv
// Front-panel driver for the alarm clock: button sync/debounce, set-mode FSM,
// alarm-enable toggle and the Pulse timebase divider.
module panel_input_ctrl #(
  parameter int CLK_DIV   = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_timeset_raw,
  input  logic       btn_alarmset_raw,
  input  logic       btn_minadv_raw,
  input  logic       btn_hrsadv_raw,
  input  logic       btn_alarmon_raw,
  output logic       Pulse,
  output logic       Timeset,
  output logic       Alarmset,
  output logic       Minadv,
  output logic       Hrsadv,
  output logic       Alarmon,
  output logic [1:0] mode
);

  localparam int               HALF    = CLK_DIV / 2;
  localparam int               PW      = $clog2(HALF);
  localparam logic [PW-1:0]    P_LAST  = PW'(HALF - 1);
  localparam int               DBW     = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0]   DB_LAST = DBW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_TSET = 2'b01,
    ST_ASET = 2'b10
  } state_t;

  // Bit order: 0 timeset, 1 alarmset, 2 minadv, 3 hrsadv, 4 alarmon
  logic [4:0] w_raw;
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] w_db;

  assign w_raw = {btn_alarmon_raw, btn_hrsadv_raw, btn_minadv_raw,
                  btn_alarmset_raw, btn_timeset_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_db
      logic [DBW-1:0] r_cnt;
      logic           r_level;

      // Any return of the synced input to the accepted level restarts the count.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
        end else if (r_sync2[gi] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == DB_LAST) begin
          r_level <= r_sync2[gi];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_db[gi] = r_level;
    end
  endgenerate

  logic [PW-1:0] r_pcnt;
  logic          r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt  <= '0;
      r_pulse <= 1'b0;
    end else if (r_pcnt == P_LAST) begin
      r_pcnt  <= '0;
      r_pulse <= ~r_pulse;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  state_t r_state;
  state_t w_state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_next;
  end

  // Simultaneous presses hold RUN; no direct TSET<->ASET path.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_db[0] && !w_db[1])      w_state_next = ST_TSET;
        else if (w_db[1] && !w_db[0]) w_state_next = ST_ASET;
      end
      ST_TSET: if (!w_db[0]) w_state_next = ST_RUN;
      ST_ASET: if (!w_db[1]) w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  logic r_minadv;
  logic r_hrsadv;
  logic r_alarmon;
  logic r_al_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_minadv  <= 1'b0;
      r_hrsadv  <= 1'b0;
      r_alarmon <= 1'b0;
      r_al_d    <= 1'b0;
    end else begin
      r_minadv <= w_db[2] & (r_state != ST_RUN);
      r_hrsadv <= w_db[3] & (r_state != ST_RUN);
      r_al_d   <= w_db[4];
      if (w_db[4] && !r_al_d) r_alarmon <= ~r_alarmon;
    end
  end

  assign Pulse    = r_pulse;
  assign mode     = r_state;
  assign Timeset  = r_state[0];
  assign Alarmset = r_state[1];
  assign Minadv   = r_minadv;
  assign Hrsadv   = r_hrsadv;
  assign Alarmon  = r_alarmon;

endmodule
